dma_descriptor_scheduler: RTL and testbench

Sequencer that drives the ramDmaCi custom-instruction port on behalf of a descriptor queue. Accepts DMA descriptors into a small FIFO and, per descriptor, programs bus address, memory address, block size and burst size. It then starts the transfer, polls the status word until the engine is idle, and reports completion or error. It sits between a requester and the ramDmaCi CI port, replacing software polling loops.

---
 rtl/dma_descriptor_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_dma_descriptor_scheduler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_descriptor_scheduler.sv
// Descriptor-queue sequencer for the ramDmaCi CI port: programs each transfer,
// starts it, polls status until idle and reports completion or error.
module dma_descriptor_scheduler #(
  parameter logic [7:0] CUSTOM_ID  = 8'h00,
  parameter int         FIFO_DEPTH = 4,
  parameter int         POLL_GAP   = 4,
  parameter int         TIMEOUT    = 65535
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        descValid,
  output logic        descReady,
  input  logic [31:0] descBusAddress,
  input  logic [8:0]  descMemAddress,
  input  logic [9:0]  descBlockSize,
  input  logic [7:0]  descBurstSize,
  input  logic        descIsWrite,
  output logic        ciStart,
  output logic [7:0]  ciN,
  output logic [31:0] ciValueA,
  output logic [31:0] ciValueB,
  input  logic        ciDone,
  input  logic [31:0] ciResult,
  output logic        cmplValid,
  output logic        cmplError,
  output logic        busy,
  output logic [4:0]  queueLevel
);

  localparam int          AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          GW      = $clog2(POLL_GAP + 1);
  localparam logic [15:0] TMO     = 16'(TIMEOUT);
  localparam logic [4:0]  DEPTH_L = 5'(FIFO_DEPTH);
  localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

  typedef struct packed {
    logic [31:0] bus;
    logic [8:0]  mem;
    logic [9:0]  size;
    logic [7:0]  burst;
    logic        is_write;
  } desc_t;

  typedef enum logic [3:0] {
    IDLE, CHECK, CFG_BUS, CFG_MEM, CFG_SIZE, CFG_BURST, START,
    GAP, POLL_ISSUE, POLL_WAIT, COMPLETE
  } state_t;

  state_t          state;
  desc_t           job;
  desc_t           fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [4:0]      level;
  logic [GW-1:0]   gap_cnt;
  logic [15:0]     polls;
  logic            pending;
  logic            push, pop, done;
  logic            unused_res;

  assign ciN        = CUSTOM_ID;
  assign descReady  = (level != DEPTH_L);
  assign queueLevel = level;
  assign push       = descValid & descReady;
  assign pop        = (state == IDLE) && (level != 5'd0);
  // A done strobe only counts while an operation is in flight.
  assign done       = ciDone & (ciStart | pending);
  assign unused_res = ^ciResult[31:2];

  always_ff @(posedge clock) begin
    if (push)
      fifo_mem[wr_ptr] <= '{descBusAddress, descMemAddress, descBlockSize,
                             descBurstSize, descIsWrite};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 5'd1;
        2'b01:   level <= level - 5'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      job       <= '0;
      gap_cnt   <= '0;
      polls     <= '0;
      pending   <= 1'b0;
      ciStart   <= 1'b0;
      ciValueA  <= '0;
      ciValueB  <= '0;
      cmplValid <= 1'b0;
      cmplError <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ciStart   <= 1'b0;
      ciValueA  <= '0;
      ciValueB  <= '0;
      cmplValid <= 1'b0;
      cmplError <= 1'b0;
      pending   <= (ciStart | pending) & ~ciDone;
      case (state)
        IDLE: if (pop) begin
          job   <= fifo_mem[rd_ptr];
          polls <= '0;
          busy  <= 1'b1;
          state <= CHECK;
        end
        CHECK: begin
          if (job.size == 10'd0) begin
            cmplValid <= 1'b1;
            state     <= COMPLETE;
          end else if (job.size > 10'd512) begin
            cmplValid <= 1'b1;
            cmplError <= 1'b1;
            state     <= COMPLETE;
          end else begin
            ciStart  <= 1'b1;
            ciValueA <= 32'h600;
            ciValueB <= job.bus;
            state    <= CFG_BUS;
          end
        end
        CFG_BUS: if (done) begin
          ciStart  <= 1'b1;
          ciValueA <= 32'hA00;
          ciValueB <= {23'd0, job.mem};
          state    <= CFG_MEM;
        end
        CFG_MEM: if (done) begin
          ciStart  <= 1'b1;
          ciValueA <= 32'hE00;
          ciValueB <= {22'd0, job.size};
          state    <= CFG_SIZE;
        end
        CFG_SIZE: if (done) begin
          ciStart  <= 1'b1;
          ciValueA <= 32'h1200;
          ciValueB <= {24'd0, job.burst};
          state    <= CFG_BURST;
        end
        CFG_BURST: if (done) begin
          ciStart  <= 1'b1;
          ciValueA <= 32'h1600;
          ciValueB <= job.is_write ? 32'd2 : 32'd1;
          state    <= START;
        end
        START: if (done) begin
          gap_cnt <= '0;
          state   <= GAP;
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) state <= POLL_ISSUE;
          else                     gap_cnt <= gap_cnt + 1'b1;
        end
        POLL_ISSUE: begin
          ciStart  <= 1'b1;
          ciValueA <= 32'h1400;
          if (polls != 16'hFFFF) polls <= polls + 16'd1;
          state    <= POLL_WAIT;
        end
        POLL_WAIT: if (done) begin
          if (ciResult[0] && polls < TMO) begin
            gap_cnt <= '0;
            state   <= GAP;
          end else begin
            cmplValid <= 1'b1;
            cmplError <= ciResult[0] | ciResult[1];
            state     <= COMPLETE;
          end
        end
        COMPLETE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_descriptor_scheduler.sv
// Scoreboard bench: each accepted descriptor queues its expected CI operations
// and completion; a monitor checks the DUT against those queues every cycle.
module tb_dma_descriptor_scheduler;
  localparam logic [7:0] CID = 8'h5A;
  localparam int DEPTH = 4, PGAP = 4, TMO = 3;

  logic clock = 0, reset = 0;
  logic descValid = 0, descReady, descIsWrite = 0;
  logic [31:0] descBusAddress = 0;
  logic [8:0]  descMemAddress = 0;
  logic [9:0]  descBlockSize = 0;
  logic [7:0]  descBurstSize = 0;
  logic ciStart, ciDone, cmplValid, cmplError, busy;
  logic [7:0]  ciN;
  logic [31:0] ciValueA, ciValueB, ciResult = 0;
  logic [4:0]  queueLevel;
  logic stat_done = 0;

  always #5 clock = ~clock;

  dma_descriptor_scheduler #(.CUSTOM_ID(CID), .FIFO_DEPTH(DEPTH), .POLL_GAP(PGAP), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .descValid(descValid), .descReady(descReady),
    .descBusAddress(descBusAddress), .descMemAddress(descMemAddress),
    .descBlockSize(descBlockSize), .descBurstSize(descBurstSize), .descIsWrite(descIsWrite),
    .ciStart(ciStart), .ciN(ciN), .ciValueA(ciValueA), .ciValueB(ciValueB),
    .ciDone(ciDone), .ciResult(ciResult), .cmplValid(cmplValid), .cmplError(cmplError),
    .busy(busy), .queueLevel(queueLevel));

  // Engine: config writes finish at once, status reads answer one cycle later.
  assign ciDone = (ciStart && ciValueA != 32'h1400) || stat_done;

  typedef struct { logic [31:0] a; logic [31:0] b; } op_t;
  typedef struct { int busy_reads; bit err; } eng_t;
  op_t  exp_ops[$];
  bit   exp_err[$];
  eng_t eng_q[$];
  int total = 0, bad = 0, cyc = 0;
  bit stat_pend = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: an in-range job emits five config writes, then one status read
  // per busy answer plus the final one, capped at TMO reads.
  function automatic void add_job(input logic [31:0] bus, input logic [8:0] mem,
      input logic [9:0] size, input logic [7:0] burst, input bit wr, input int nb, input bit err);
    int reads;
    if (size == 0) exp_err.push_back(1'b0);
    else if (size > 512) exp_err.push_back(1'b1);
    else begin
      exp_ops.push_back('{32'h600, bus});
      exp_ops.push_back('{32'hA00, {23'd0, mem}});
      exp_ops.push_back('{32'hE00, {22'd0, size}});
      exp_ops.push_back('{32'h1200, {24'd0, burst}});
      exp_ops.push_back('{32'h1600, wr ? 32'd2 : 32'd1});
      reads = (nb >= TMO) ? TMO : nb + 1;
      for (int i = 0; i < reads; i++) exp_ops.push_back('{32'h1400, 32'd0});
      exp_err.push_back((nb >= TMO) ? 1'b1 : err);
      eng_q.push_back('{nb, err});
    end
  endfunction

  initial begin : engine
    int left = 0;
    bit cur_err = 0;
    logic [31:0] res = 0;
    eng_t e;
    forever begin
      @(negedge clock);
      stat_done = stat_pend;
      ciResult  = stat_pend ? res : 32'd0;
      stat_pend = 0;
      if (reset && ciStart) begin
        if (ciValueA == 32'h1600 && eng_q.size() > 0) begin
          e = eng_q.pop_front(); left = e.busy_reads; cur_err = e.err;
        end else if (ciValueA == 32'h1400) begin
          stat_pend = 1;
          if (left > 0) begin res = 32'd1; left--; end
          else res = {30'd0, cur_err, 1'b0};
        end
      end
    end
  end

  initial begin : monitor
    int start_cyc = 0;
    bit first_poll = 0;
    op_t o;
    bit e;
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset) continue;
      if (ciStart) begin
        chk("ci_n", ciN, CID);
        if (exp_ops.size() == 0) chk("unexpected_ci_op", ciValueA, 32'hFFFF_FFFF);
        else begin
          o = exp_ops.pop_front();
          chk("ci_a", ciValueA, o.a);
          chk("ci_b", ciValueB, o.b);
        end
        if (ciValueA == 32'h1600) begin start_cyc = cyc; first_poll = 1; end
        if (ciValueA == 32'h1400 && first_poll) begin
          chk("first_poll_gap_ok", (cyc - start_cyc) >= PGAP + 1, 1);
          first_poll = 0;
        end
      end else if (ciValueA != 0 || ciValueB != 0)
        chk("ci_values_idle", {ciValueA, ciValueB}, 64'd0);
      if (cmplValid) begin
        if (exp_err.size() == 0) chk("unexpected_cmpl", 1, 0);
        else begin
          e = exp_err.pop_front();
          chk("cmpl_error", cmplError, e);
        end
      end
    end
  end

  task automatic push_desc(input logic [31:0] bus, input logic [8:0] mem, input logic [9:0] size,
      input logic [7:0] burst, input bit wr, input int nb, input bit err);
    int n = 0;
    @(negedge clock);
    while (!descReady && n < 400) begin @(negedge clock); n++; end
    if (n >= 400) begin chk("push_ready_timeout", 0, 1); return; end
    descBusAddress = bus; descMemAddress = mem; descBlockSize = size;
    descBurstSize = burst; descIsWrite = wr; descValid = 1;
    add_job(bus, mem, size, burst, wr, nb, err);
    @(negedge clock);
    descValid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || queueLevel != 0 || exp_err.size() != 0) && n < 2000) begin
      @(negedge clock); n++;
    end
    if (n >= 2000) chk("idle_timeout", 0, 1);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin : stim
    int n, lvl;
    bit acc;
    // Reset state
    #3;
    chk("rst_descReady", descReady, 1);
    chk("rst_busy", busy, 0);
    chk("rst_level", queueLevel, 0);
    chk("rst_ciStart", ciStart, 0);
    chk("rst_ciN", ciN, CID);
    chk("rst_cmplValid", cmplValid, 0);
    chk("rst_ciValueA", ciValueA, 0);
    repeat (3) @(negedge clock);
    reset = 1;

    // Single DMA in, then DMA out with bus error, then timeout
    push_desc(32'h1000, 9'd16, 10'd8, 8'd3, 0, 2, 0);
    wait_idle();
    push_desc(32'h2000, 9'd5, 10'd64, 8'd7, 1, 1, 1);
    wait_idle();
    push_desc(32'h3000, 9'd0, 10'd512, 8'd0, 0, 100, 0);
    wait_idle();

    // Size 0 completes within 3 cycles of the push; size 600 errors, no CI traffic
    push_desc(32'h4000, 9'd1, 10'd0, 8'd1, 0, 0, 0);
    n = 1;
    while (!cmplValid && n < 3) begin @(negedge clock); n++; end
    chk("size0_cmpl_latency_ok", cmplValid, 1);
    wait_idle();
    push_desc(32'h5000, 9'd1, 10'd600, 8'd1, 0, 0, 0);
    wait_idle();

    // FIFO fill while a long job is in flight
    push_desc(32'hE000, 9'd2, 10'd4, 8'd1, 0, 100, 0);
    n = 0;
    while ((queueLevel != 0 || !busy) && n < 20) begin @(negedge clock); n++; end
    chk("fill_start_level", queueLevel, 0);
    lvl = 0;
    for (int i = 0; i < 5; i++) begin
      descBusAddress = 32'hF000 + i; descMemAddress = 9'(i); descBlockSize = 10'd4;
      descBurstSize = 8'd0; descIsWrite = i[0]; descValid = 1;
      acc = (lvl < DEPTH);
      if (acc) begin lvl++; add_job(32'hF000 + i, 9'(i), 10'd4, 8'd0, i[0], i % 3, 0); end
      @(negedge clock);
      chk("fill_level", queueLevel, lvl);
      chk("fill_ready", descReady, lvl < DEPTH);
    end
    descValid = 0;
    wait_idle();

    // Randomised descriptors
    for (int k = 0; k < 14; k++) begin
      int r = $urandom_range(0, 9);
      logic [9:0] sz = (r == 0) ? 10'd0 : (r == 1) ? 10'(513 + $urandom_range(0, 510))
                                                   : 10'($urandom_range(1, 512));
      push_desc($urandom, 9'($urandom), sz, 8'($urandom), 1'($urandom), $urandom_range(0, 4), 1'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
    wait_idle();

    // Async reset during POLL_WAIT with more work queued
    push_desc(32'hAA00, 9'd3, 10'd9, 8'd2, 0, 100, 0);
    push_desc(32'hBB00, 9'd3, 10'd9, 8'd2, 0, 0, 0);
    push_desc(32'hCC00, 9'd3, 10'd9, 8'd2, 0, 0, 0);
    n = 0;
    while (!(ciStart && ciValueA == 32'h1400) && n < 200) begin @(negedge clock); n++; end
    chk("reach_poll_wait", n < 200, 1);
    #2;
    reset = 0;
    #1;
    chk("arst_ciStart", ciStart, 0);
    chk("arst_busy", busy, 0);
    chk("arst_level", queueLevel, 0);
    chk("arst_descReady", descReady, 1);
    chk("arst_ciValueA", ciValueA, 0);
    exp_ops.delete(); exp_err.delete(); eng_q.delete();
    stat_pend = 0;
    repeat (3) @(negedge clock);
    reset = 1;
    repeat (10) @(negedge clock);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_level", queueLevel, 0);

    // One more job after reset to show recovery
    push_desc(32'hDD00, 9'd7, 10'd1, 8'd0, 1, 0, 0);
    wait_idle();
    chk("ops_drained", exp_ops.size(), 0);
    chk("engine_drained", eng_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
